// File: rtl/cpe142_pkg.sv
// Shared types and constants for the hazard/stall control slice.
// State encodings, the zero-register id and the multiply/divide default.
package cpe142_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    MULDIV = 2'b01
  } hazState_t;

  localparam logic [3:0] REG_ZERO = 4'b0000;
  localparam int MULDIV_CYCLES_DEF = 4;
  localparam int DOWN_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// A clear wins over an increment in the same cycle.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: branch flush, load-use stall, and
// multi-cycle multiply/divide hold, plus stall/flush counters.
module hazard_stall_unit
  import cpe142_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       IF_ID_op1,
  input  logic [3:0]       IF_ID_op2,
  input  logic [3:0]       ID_EX_dest,
  input  logic             ID_EX_memRead,
  input  logic             ID_EX_muldiv,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             PCWrite,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             EX_hold,
  output logic [1:0]       hazard_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // RUN stalls one cycle, MULDIV covers the remaining cycles.
  localparam logic [DOWN_W-1:0] MD_LOAD = DOWN_W'(MULDIV_CYCLES - 3);

  hazState_t         state;
  hazState_t         nextState;
  logic [DOWN_W-1:0] downCnt;
  logic [DOWN_W-1:0] nextDown;
  logic              loadUse;

  assign loadUse = ID_EX_memRead
                && (ID_EX_dest != REG_ZERO)
                && ((ID_EX_dest == IF_ID_op1)
                 || (ID_EX_dest == IF_ID_op2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      downCnt <= '0;
    end else begin
      state   <= nextState;
      downCnt <= nextDown;
    end
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    EX_hold      = 1'b0;
    nextState    = state;
    nextDown     = downCnt;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (ID_EX_muldiv) begin
            PCWrite     = 1'b0;
            IF_ID_write = 1'b0;
            EX_hold     = 1'b1;
            nextState   = MULDIV;
            nextDown    = MD_LOAD;
          end else if (loadUse) begin
            PCWrite      = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
          end
        end
        MULDIV: begin
          PCWrite     = 1'b0;
          IF_ID_write = 1'b0;
          EX_hold     = 1'b1;
          if (downCnt == '0) begin
            nextState = RUN;
          end else begin
            nextDown = downCnt - 1'b1;
          end
        end
        default: nextState = RUN;
      endcase
    end
  end

  assign hazard_state = state;

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~PCWrite),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IF_ID_flush),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with hand-computed
// expectations checked by immediate assertions.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] IF_ID_op1, IF_ID_op2, ID_EX_dest;
  logic       ID_EX_memRead, ID_EX_muldiv, branch_taken, cnt_clr;
  logic       PCWrite, IF_ID_write, ID_EX_bubble, IF_ID_flush, EX_hold;
  logic [1:0] hazard_state;
  logic [7:0] stall_cnt, flush_cnt;

  int nAsserts = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IF_ID_op1     (IF_ID_op1),
    .IF_ID_op2     (IF_ID_op2),
    .ID_EX_dest    (ID_EX_dest),
    .ID_EX_memRead (ID_EX_memRead),
    .ID_EX_muldiv  (ID_EX_muldiv),
    .branch_taken  (branch_taken),
    .cnt_clr       (cnt_clr),
    .PCWrite       (PCWrite),
    .IF_ID_write   (IF_ID_write),
    .ID_EX_bubble  (ID_EX_bubble),
    .IF_ID_flush   (IF_ID_flush),
    .EX_hold       (EX_hold),
    .hazard_state  (hazard_state),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pc, ifw, bubble, flush, hold, state
  task automatic outs(input string tag, input logic pc, input logic ifw,
                      input logic bub, input logic fl, input logic hold,
                      input logic [1:0] st);
    chk({tag, ".PCWrite"}, 32'(PCWrite), 32'(pc));
    chk({tag, ".IF_ID_write"}, 32'(IF_ID_write), 32'(ifw));
    chk({tag, ".ID_EX_bubble"}, 32'(ID_EX_bubble), 32'(bub));
    chk({tag, ".IF_ID_flush"}, 32'(IF_ID_flush), 32'(fl));
    chk({tag, ".EX_hold"}, 32'(EX_hold), 32'(hold));
    chk({tag, ".state"}, 32'(hazard_state), 32'(st));
  endtask

  task automatic cnts(input string tag, input int s, input int f);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(s));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(f));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    IF_ID_op1 = 4'd1;
    IF_ID_op2 = 4'd2;
    ID_EX_dest = 4'd7;
    ID_EX_memRead = 1'b0;
    ID_EX_muldiv = 1'b0;
    branch_taken = 1'b0;
    cnt_clr = 1'b0;
  endtask

  initial begin
    idleIn();
    rst_n = 1'b0;
    branch_taken = 1'b1;
    tick();
    tick();
    #1;
    outs("rst_idle", 1, 1, 0, 0, 0, 2'b00);
    cnts("rst", 0, 0);

    rst_n = 1'b1;
    idleIn();
    #1;
    outs("idle", 1, 1, 0, 0, 0, 2'b00);

    // load-use on op2
    ID_EX_memRead = 1'b1;
    ID_EX_dest = 4'b1001;
    IF_ID_op2 = 4'b1001;
    IF_ID_op1 = 4'b0011;
    #1;
    outs("lu_op2", 0, 0, 1, 0, 0, 2'b00);
    tick();
    cnts("lu_op2", 1, 0);

    // load-use on op1
    ID_EX_dest = 4'b0101;
    IF_ID_op1 = 4'b0101;
    IF_ID_op2 = 4'b0000;
    #1;
    outs("lu_op1", 0, 0, 1, 0, 0, 2'b00);
    tick();
    cnts("lu_op1", 2, 0);

    // match but not a load
    ID_EX_memRead = 1'b0;
    #1;
    outs("noload", 1, 1, 0, 0, 0, 2'b00);
    tick();

    // register zero never hazards
    ID_EX_memRead = 1'b1;
    ID_EX_dest = 4'b0000;
    IF_ID_op1 = 4'b0000;
    #1;
    outs("rzero", 1, 1, 0, 0, 0, 2'b00);
    tick();
    cnts("rzero", 2, 0);

    // muldiv held three cycles
    idleIn();
    ID_EX_muldiv = 1'b1;
    #1;
    outs("md0", 0, 0, 0, 0, 1, 2'b00);
    tick();
    branch_taken = 1'b1;
    ID_EX_memRead = 1'b1;
    ID_EX_dest = 4'd3;
    IF_ID_op1 = 4'd3;
    #1;
    outs("md1", 0, 0, 0, 0, 1, 2'b01);
    tick();
    #1;
    outs("md2", 0, 0, 0, 0, 1, 2'b01);
    tick();
    idleIn();
    #1;
    outs("md_done", 1, 1, 0, 0, 0, 2'b00);
    cnts("md", 5, 0);

    // priority: branch over muldiv over load-use
    branch_taken = 1'b1;
    ID_EX_muldiv = 1'b1;
    ID_EX_memRead = 1'b1;
    ID_EX_dest = 4'd4;
    IF_ID_op1 = 4'd4;
    #1;
    outs("prio", 1, 1, 1, 1, 0, 2'b00);
    tick();
    idleIn();
    #1;
    outs("prio_after", 1, 1, 0, 0, 0, 2'b00);
    cnts("prio", 5, 1);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    cnts("clr", 0, 0);

    // saturation
    ID_EX_memRead = 1'b1;
    ID_EX_dest = 4'd6;
    IF_ID_op2 = 4'd6;
    for (int i = 0; i < 254; i++) tick();
    cnts("sat254", 254, 0);
    for (int i = 0; i < 46; i++) tick();
    cnts("sat300", 255, 0);
    cnt_clr = 1'b1;
    #1;
    outs("clr_stall", 0, 0, 1, 0, 0, 2'b00);
    tick();
    cnts("clr_stall", 0, 0);
    idleIn();

    // reset during MULDIV
    ID_EX_muldiv = 1'b1;
    tick();
    #1;
    outs("mdr1", 0, 0, 0, 0, 1, 2'b01);
    cnts("mdr1", 1, 0);
    rst_n = 1'b0;
    #1;
    outs("mdr_rst", 1, 1, 0, 0, 0, 2'b01);
    tick();
    outs("mdr_after", 1, 1, 0, 0, 0, 2'b00);
    cnts("mdr_after", 0, 0);
    ID_EX_muldiv = 1'b0;
    rst_n = 1'b1;
    #1;
    outs("mdr_run", 1, 1, 0, 0, 0, 2'b00);
    tick();
    cnts("mdr_run", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter MULDIV_CYCLES, default 4: EX-stage occupancy of a multiply/divide; legal range 3..16.
REQ-003 Parameter CNT_W, default 8: width of the stall and flush counters.
REQ-004 Port clk  input  1: rising-edge clock.
REQ-005 Port rst_n  input  1: synchronous active-low reset.
REQ-006 Port IF_ID_op1  input  4: source register 1 of the decode instruction.
REQ-007 Port IF_ID_op2  input  4: source register 2 of the decode instruction.
REQ-008 Port ID_EX_dest  input  4: destination register of the EX instruction.
REQ-009 Port ID_EX_memRead  input  1: EX instruction is a load.
REQ-010 Port ID_EX_muldiv  input  1: EX instruction is a multiply/divide.
REQ-011 Port branch_taken  input  1: EX resolved a taken branch.
REQ-012 Port cnt_clr  input  1: clear both counters.
REQ-013 Port PCWrite  output  1: 1 = PC may update.
REQ-014 Port IF_ID_write  output  1: 1 = IF/ID register may load.
REQ-015 Port ID_EX_bubble  output  1: 1 = load NOP controls into ID/EX.
REQ-016 Port IF_ID_flush  output  1: 1 = squash IF/ID contents.
REQ-017 Port EX_hold  output  1: 1 = freeze ID/EX and EX/MEM.
REQ-018 Port hazard_state  output  2: current FSM state.
REQ-019 Port stall_cnt  output  CNT_W: saturating count of stall cycles.
REQ-020 Port flush_cnt  output  CNT_W: saturating count of flushes.

Function
REQ-021 FSM states SHALL be RUN=2'b00 and MULDIV=2'b01; hazard_state SHALL equal the state register.
REQ-022 Idle outputs in RUN SHALL be PCWrite=1, IF_ID_write=1, ID_EX_bubble=0, IF_ID_flush=0, EX_hold=0.
REQ-023 In RUN, outputs SHALL be combinational (same-cycle) from the state and inputs, with priority branch > muldiv > load-use.
REQ-024 Branch in RUN: branch_taken=1 SHALL assert IF_ID_flush=1 and ID_EX_bubble=1 with PCWrite=1, and the state SHALL stay RUN.
REQ-025 Muldiv in RUN: ID_EX_muldiv=1 SHALL assert PCWrite=0, IF_ID_write=0 and EX_hold=1, load the down-counter with MULDIV_CYCLES-3 and move to MULDIV.
REQ-026 In MULDIV: PCWrite=0, IF_ID_write=0 and EX_hold=1; the down-counter SHALL decrement each cycle, with exit to RUN on the edge where it reads 0.
REQ-027 Total stall per multiply/divide SHALL be exactly MULDIV_CYCLES-1 cycles.
REQ-028 Load-use in RUN: ID_EX_memRead=1 and ID_EX_dest!=4'b0000 and (ID_EX_dest==IF_ID_op1 or ID_EX_dest==IF_ID_op2) SHALL assert PCWrite=0, IF_ID_write=0 and ID_EX_bubble=1 for that cycle only; the state SHALL stay RUN.
REQ-029 Register 4'b0000 SHALL never raise a load-use hazard.
REQ-030 In MULDIV, branch_taken, ID_EX_memRead and the still-held ID_EX_muldiv SHALL be ignored.
REQ-031 stall_cnt SHALL increment on each edge where PCWrite=0.
REQ-032 flush_cnt SHALL increment on each edge where IF_ID_flush=1.
REQ-033 Both counters SHALL saturate at 2^CNT_W-1, and cnt_clr=1 SHALL zero them, overriding any increment in the same cycle.

Reset
REQ-034 While rst_n=0, outputs SHALL take the idle values of REQ-022.
REQ-035 On a clk edge with rst_n=0: state=RUN, down-counter=0, stall_cnt=0, flush_cnt=0, including when reset arrives mid-MULDIV.

Structure
REQ-036 Package cpe142_pkg SHALL hold the state encodings, the REG_ZERO=4'b0000 constant and the MULDIV_CYCLES default.
REQ-037 One sub-module, sat_counter (parameter CNT_W; ports inc, clr), SHALL be instantiated twice, once per counter.

Verification
REQ-038 Load-use: memRead=1, dest=4'b1001, IF_ID_op2=4'b1001 -> one cycle of PCWrite=0, IF_ID_write=0, ID_EX_bubble=1; stall_cnt=1.
REQ-039 Register zero: memRead=1, dest=4'b0000, IF_ID_op1=4'b0000 -> all outputs idle; stall_cnt unchanged.
REQ-040 Muldiv: ID_EX_muldiv=1 held 3 cycles -> EX_hold=1 and PCWrite=0 for exactly 3 cycles; hazard_state 00,01,01,00; stall_cnt=3.
REQ-041 Priority: branch_taken=1, muldiv=1, memRead=1 in RUN -> IF_ID_flush=1, ID_EX_bubble=1, PCWrite=1, EX_hold=0; flush_cnt=1.
REQ-042 Saturation: 300 back-to-back load-use cycles -> stall_cnt=255; cnt_clr=1 together with a stall -> stall_cnt=0 next cycle.
REQ-043 Reset mid-op: rst_n=0 during the second MULDIV cycle -> next edge hazard_state=00, both counters 0, outputs idle.
